// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared state encoding and constants for the DM arbiter
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    ACK   = 2'd2
  } state_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  // DM is word-addressed; the byte offset never reaches it
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/be_merge.sv
// rtl/be_merge.sv - byte-enable merge of a new store word into an old DM word
module be_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  // take byte k from the new word when its enable is set, else keep the old byte
  always_comb begin
    merged = old_word;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) merged[8*k +: 8] = new_word[8*k +: 8];
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port round-robin data-memory arbiter with partial-store merge
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter logic INIT_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        we0,
  input  logic [3:0]  be0,
  input  logic [31:0] addr0,
  input  logic [31:0] wdata0,
  input  logic [31:0] pc0,
  input  logic        req1,
  input  logic        we1,
  input  logic [3:0]  be1,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic [31:0] rdata0,
  output logic        ack1,
  output logic [31:0] rdata1,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_we,
  output logic [31:0] dm_pc,
  input  logic [31:0] dm_rdata
);

  state_t      state;
  logic        owner;
  logic        last;
  logic [31:0] addr_q;
  logic [31:0] merged_q;

  logic        gnt_valid;
  logic        gnt;
  logic        sel_we;
  logic [3:0]  sel_be;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_partial;
  logic [31:0] merge_word;

  // pick the port to grant in IDLE: sole requester, or the one not served last
  always_comb begin
    gnt_valid   = req0 | req1;
    gnt         = (req0 & req1) ? ~last : req1;
    sel_we      = gnt ? we1    : we0;
    sel_be      = gnt ? be1    : be0;
    sel_addr    = gnt ? addr1  : addr0;
    sel_wdata   = gnt ? wdata1 : wdata0;
    sel_partial = (sel_be != BE_FULL) && (sel_be != 4'h0);
  end

  be_merge u_merge (
    .old_word (dm_rdata),
    .new_word (sel_wdata),
    .be       (sel_be),
    .merged   (merge_word)
  );

  // DM side: grant-cycle access in IDLE, merged write-back in MERGE, quiet in ACK
  always_comb begin
    dm_we    = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;
    dm_pc    = 32'h0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          dm_addr  = word_align(sel_addr);
          dm_wdata = sel_wdata;
          dm_we    = sel_we & (sel_be == BE_FULL);
          dm_pc    = gnt ? 32'h0 : pc0;
        end
      end
      MERGE: begin
        dm_addr  = addr_q;
        dm_wdata = merged_q;
        dm_we    = 1'b1;
        dm_pc    = owner ? 32'h0 : pc0;
      end
      ACK: begin
        dm_pc = owner ? 32'h0 : pc0;
      end
      default: ;
    endcase
    // a reset arriving mid-merge must not let the pending write reach DM
    if (rst) dm_we = 1'b0;
  end

  // arbitration FSM with registered acks, load data and merge context
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= 1'b0;
      last     <= INIT_LAST;
      addr_q   <= 32'h0;
      merged_q <= 32'h0;
      rdata0   <= 32'h0;
      rdata1   <= 32'h0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner <= gnt;
            last  <= gnt;
            if (!sel_we) begin
              if (gnt) rdata1 <= dm_rdata;
              else     rdata0 <= dm_rdata;
            end
            if (sel_we && sel_partial) begin
              merged_q <= merge_word;
              addr_q   <= word_align(sel_addr);
              state    <= MERGE;
            end else begin
              ack0  <= ~gnt;
              ack1  <= gnt;
              state <= ACK;
            end
          end
        end
        MERGE: begin
          ack0  <= ~owner;
          ack1  <= owner;
          state <= ACK;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - self-checking bench for dm_arbiter against a transaction-level model
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [3:0]  be0 = 4'h0, be1 = 4'h0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0, pc0 = 32'h0;
  logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
  logic        ack0, ack1, dm_we;
  logic [31:0] rdata0, rdata1, dm_addr, dm_wdata, dm_pc, dm_rdata;

  logic        mem_clr = 1'b0;
  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rd  [0:1];
  int          n_cmp = 0;
  int          n_fail = 0;

  dm_arbiter #(.INIT_LAST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .be0(be0), .addr0(addr0), .wdata0(wdata0), .pc0(pc0),
    .req1(req1), .we1(we1), .be1(be1), .addr1(addr1), .wdata1(wdata1),
    .ack0(ack0), .rdata0(rdata0), .ack1(ack1), .rdata1(rdata1),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_pc(dm_pc),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // behavioural data memory: combinational read, write on posedge
  assign dm_rdata = mem[dm_addr[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (dm_we) begin
      mem[dm_addr[7:2]] <= dm_wdata;
    end
  end

  task automatic drive_port(input int p, input logic r, input logic w, input logic [3:0] b,
                            input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin req0 = r; we0 = w; be0 = b; addr0 = a; wdata0 = d; end
    else        begin req1 = r; we1 = w; be1 = b; addr1 = a; wdata1 = d; end
  endtask

  task automatic do_reset(input logic clr);
    @(posedge clk); #1;
    rst = 1'b1; mem_clr = clr; req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; mem_clr = 1'b0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    if (clr) for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
  endtask

  // one access on port p, started in an IDLE cycle, checked against the model
  task automatic run_txn(input int p, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
    int idx, exp_lat, exp_wes, lat, wes, wcyc;
    logic got, acko;
    logic [31:0] oldv, newv, mask, wa, wd, wp;
    idx     = int'(a[7:2]);
    oldv    = ref_mem[idx];
    mask    = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    newv    = w ? ((d & mask) | (oldv & ~mask)) : oldv;
    exp_lat = (w && b != 4'hF && b != 4'h0) ? 3 : 2;
    exp_wes = (w && b != 4'h0) ? 1 : 0;
    pc0     = $urandom;
    drive_port(p, 1'b1, w, b, a, d);
    got = 1'b0; lat = 0; wes = 0; wcyc = 0; acko = 1'b0;
    wa = 32'h0; wd = 32'h0; wp = 32'h0;
    for (int n = 1; n <= 6 && !got; n++) begin
      @(negedge clk);
      if (dm_we) begin wes++; wcyc = n; wa = dm_addr; wd = dm_wdata; wp = dm_pc; end
      if ((p == 0) ? ack0 : ack1) begin got = 1'b1; lat = n; acko = (p == 0) ? ack1 : ack0; end
    end
    drive_port(p, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    if (w) ref_mem[idx] = newv;
    else   exp_rd[p] = oldv;
    n_cmp++; if (lat !== exp_lat) begin n_fail++; $display("FAIL latency p%0d: got %0d want %0d", p, lat, exp_lat); end
    n_cmp++; if (acko !== 1'b0) begin n_fail++; $display("FAIL foreign_ack p%0d: got %b want 0", p, acko); end
    n_cmp++; if (wes !== exp_wes) begin n_fail++; $display("FAIL we_count p%0d: got %0d want %0d", p, wes, exp_wes); end
    if (exp_wes == 1) begin
      n_cmp++; if (wcyc !== exp_lat - 1) begin n_fail++; $display("FAIL we_cycle: got %0d want %0d", wcyc, exp_lat - 1); end
      n_cmp++; if (wa !== {a[31:2], 2'b00}) begin n_fail++; $display("FAIL we_addr: got %h want %h", wa, {a[31:2], 2'b00}); end
      n_cmp++; if (wd !== newv) begin n_fail++; $display("FAIL we_data: got %h want %h", wd, newv); end
      n_cmp++; if (wp !== ((p == 0) ? pc0 : 32'h0)) begin n_fail++; $display("FAIL dm_pc: got %h want %h", wp, (p == 0) ? pc0 : 32'h0); end
    end
    n_cmp++; if (rdata0 !== exp_rd[0]) begin n_fail++; $display("FAIL rdata0: got %h want %h", rdata0, exp_rd[0]); end
    n_cmp++; if (rdata1 !== exp_rd[1]) begin n_fail++; $display("FAIL rdata1: got %h want %h", rdata1, exp_rd[1]); end
    n_cmp++; if (mem[idx] !== ref_mem[idx]) begin n_fail++; $display("FAIL mem_word[%0d]: got %h want %h", idx, mem[idx], ref_mem[idx]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset(1'b1);
    @(negedge clk);
    n_cmp++; if (ack0 !== 1'b0)     begin n_fail++; $display("FAIL reset_ack0: got %b want 0", ack0); end
    n_cmp++; if (ack1 !== 1'b0)     begin n_fail++; $display("FAIL reset_ack1: got %b want 0", ack1); end
    n_cmp++; if (rdata0 !== 32'h0)  begin n_fail++; $display("FAIL reset_rdata0: got %h want 0", rdata0); end
    n_cmp++; if (rdata1 !== 32'h0)  begin n_fail++; $display("FAIL reset_rdata1: got %h want 0", rdata1); end
    n_cmp++; if (dm_we !== 1'b0)    begin n_fail++; $display("FAIL reset_dm_we: got %b want 0", dm_we); end
    n_cmp++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL reset_dm_addr: got %h want 0", dm_addr); end
    n_cmp++; if (dm_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_wdata: got %h want 0", dm_wdata); end
    n_cmp++; if (dm_pc !== 32'h0)   begin n_fail++; $display("FAIL reset_dm_pc: got %h want 0", dm_pc); end
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_txn(1, 1'b1, 4'hF, 32'h10, 32'h11223344);
    run_txn(0, 1'b0, 4'hF, 32'h10, 32'h0);
    n_cmp++; if (rdata0 !== 32'h11223344) begin n_fail++; $display("FAIL load_0x10: got %h want 11223344", rdata0); end
    run_txn(1, 1'b1, 4'hF, 32'h22, 32'hAABBCCDD);
    run_txn(0, 1'b0, 4'hF, 32'h20, 32'h0);
    n_cmp++; if (rdata0 !== 32'hAABBCCDD) begin n_fail++; $display("FAIL load_0x20: got %h want aabbccdd", rdata0); end
    run_txn(1, 1'b1, 4'hF, 32'h40, 32'h11223344);
    run_txn(0, 1'b1, 4'b0010, 32'h40, 32'h0000EE00);
    n_cmp++; if (mem[16] !== 32'h1122EE44) begin n_fail++; $display("FAIL merge_0x40: got %h want 1122ee44", mem[16]); end
    run_txn(0, 1'b1, 4'h0, 32'h48, 32'h12345678);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      run_txn(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              32'($urandom_range(0, 255)), $urandom);
    end
  endtask

  task automatic test_back_to_back();
    int g;
    int lm;
    logic e0, e1;
    do_reset(1'b0);
    lm = 1;
    g = 0;
    req0 = 1'b1; we0 = 1'b0; be0 = 4'hF; addr0 = 32'h20;
    req1 = 1'b1; we1 = 1'b0; be1 = 4'hF; addr1 = 32'h40;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c % 2 == 1) begin g = 1 - lm; lm = g; end
      e0 = (c % 2 == 0) && (g == 0);
      e1 = (c % 2 == 0) && (g == 1);
      n_cmp++; if (ack0 !== e0) begin n_fail++; $display("FAIL rr_ack0 c%0d: got %b want %b", c, ack0, e0); end
      n_cmp++; if (ack1 !== e1) begin n_fail++; $display("FAIL rr_ack1 c%0d: got %b want %b", c, ack1, e1); end
      if (e0) begin
        n_cmp++; if (rdata0 !== ref_mem[8]) begin n_fail++; $display("FAIL rr_rdata0: got %h want %h", rdata0, ref_mem[8]); end
      end
      if (e1) begin
        n_cmp++; if (rdata1 !== ref_mem[16]) begin n_fail++; $display("FAIL rr_rdata1: got %h want %h", rdata1, ref_mem[16]); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    exp_rd[0] = ref_mem[8]; exp_rd[1] = ref_mem[16];
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_merge();
    do_reset(1'b0);
    run_txn(1, 1'b1, 4'hF, 32'h40, 32'h11223344);
    drive_port(0, 1'b1, 1'b1, 4'b0010, 32'h40, 32'h0000EE00);
    @(negedge clk);
    n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL partial_grant_we: got %b want 0", dm_we); end
    @(posedge clk); #1;
    rst = 1'b1;
    drive_port(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    @(negedge clk);
    n_cmp++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %b want 0", dm_we); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rd[0] = 32'h0; exp_rd[1] = 32'h0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({ack0, ack1, dm_we} !== 3'b000) begin n_fail++; $display("FAIL abort_quiet c%0d: got %b want 000", c, {ack0, ack1, dm_we}); end
      if (c == 0) begin
        n_cmp++; if (dm_addr !== 32'h0) begin n_fail++; $display("FAIL abort_idle_addr: got %h want 0", dm_addr); end
      end
    end
    n_cmp++; if (mem[16] !== 32'h11223344) begin n_fail++; $display("FAIL abort_mem: got %h want 11223344", mem[16]); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_in_merge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

endmodule
